// File: rtl/ddu_ctrl.sv
// DDU controller: input conditioning, CPU run enable, browse address and 7-segment scan.
// Optional breakpoint halt (pc/bp_pc ports, led[13]) is enabled by defining DDU_BREAK_EN.
module ddu_ctrl #(
    parameter int ADDR_W     = 8,
    parameter int DIGITS     = 8,
    parameter int DEB_CYCLES = 16,
    parameter int SCAN_DIV   = 1024
) (
    input  logic                  clk_500,
    input  logic                  rst,
    input  logic                  cont,
    input  logic                  step,
    input  logic                  mem,
    input  logic                  inc,
    input  logic                  dec,
    input  logic [4*DIGITS-1:0]   reg_data,
    input  logic [4*DIGITS-1:0]   mem_data,
`ifdef DDU_BREAK_EN
    input  logic [4*DIGITS-1:0]   pc,
    input  logic [4*DIGITS-1:0]   bp_pc,
`endif
    output logic                  run,
    output logic [ADDR_W-1:0]     addr,
    output logic [DIGITS-1:0]     an,
    output logic [6:0]            seg,
    output logic [15:0]           led
);

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int CW = $clog2(DEB_CYCLES + 1);

    // Synchroniser bit positions.
    localparam int S_CONT = 0;
    localparam int S_STEP = 1;
    localparam int S_MEM  = 2;
    localparam int S_INC  = 3;
    localparam int S_DEC  = 4;

    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0:    hex7 = 7'h40;
            4'h1:    hex7 = 7'h79;
            4'h2:    hex7 = 7'h24;
            4'h3:    hex7 = 7'h30;
            4'h4:    hex7 = 7'h19;
            4'h5:    hex7 = 7'h12;
            4'h6:    hex7 = 7'h02;
            4'h7:    hex7 = 7'h78;
            4'h8:    hex7 = 7'h00;
            4'h9:    hex7 = 7'h10;
            4'hA:    hex7 = 7'h08;
            4'hB:    hex7 = 7'h03;
            4'hC:    hex7 = 7'h46;
            4'hD:    hex7 = 7'h21;
            4'hE:    hex7 = 7'h06;
            4'hF:    hex7 = 7'h0E;
            default: hex7 = 7'h7F;
        endcase
    endfunction

    logic [4:0]           sync1_q, sync2_q;
    logic [2:0]           acc_q, acc_d;
    logic [2:0]           pulse_q, pulse_d;
    logic [2:0][CW-1:0]   cnt_q, cnt_d;
    logic                 run_q, run_d;
    logic                 halted_q, halted_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic [PW-1:0]        presc_q, presc_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic [DIGITS-1:0]    an_q, an_d;
    logic [6:0]           seg_q, seg_d;
    logic [2:0]           btn_s;
    logic [4*DIGITS-1:0]  word_s;

    // Debounced buttons, bit 0 = step, 1 = inc, 2 = dec.
    assign btn_s  = {sync2_q[S_DEC], sync2_q[S_INC], sync2_q[S_STEP]};
    assign word_s = sync2_q[S_MEM] ? mem_data : reg_data;

    // Next-state logic for debounce, run, address and scan.
    always_comb begin
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        pulse_d  = 3'b000;
        addr_d   = addr_q;
        presc_d  = presc_q + PW'(1);
        idx_d    = idx_q;
        an_d     = an_q;
        seg_d    = seg_q;

        for (int b = 0; b < 3; b++) begin
            if (btn_s[b] != acc_q[b]) begin
                if (cnt_q[b] == CW'(DEB_CYCLES - 1)) begin
                    acc_d[b]   = btn_s[b];
                    cnt_d[b]   = {CW{1'b0}};
                    pulse_d[b] = btn_s[b];
                end else begin
                    cnt_d[b] = cnt_q[b] + CW'(1);
                end
            end else begin
                cnt_d[b] = {CW{1'b0}};
            end
        end

`ifdef DDU_BREAK_EN
        halted_d = sync2_q[S_CONT] & (halted_q | (pc == bp_pc));
`else
        halted_d = 1'b0;
`endif
        // A step pulse re-enables exactly one cycle even while halted.
        run_d = (sync2_q[S_CONT] & ~halted_d) | pulse_q[0];

        case ({pulse_q[1], pulse_q[2]})
            2'b10:   addr_d = addr_q + ADDR_W'(1);
            2'b01:   addr_d = addr_q - ADDR_W'(1);
            default: addr_d = addr_q;
        endcase

        if (presc_q == PW'(SCAN_DIV - 1)) begin
            presc_d = {PW{1'b0}};
            idx_d   = (idx_q == IW'(DIGITS - 1)) ? {IW{1'b0}} : idx_q + IW'(1);
            an_d    = ~(DIGITS'(1) << idx_q);
            seg_d   = hex7(word_s[{idx_q, 2'b00} +: 4]);
        end else begin
            idx_d = idx_q;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk_500) begin
        if (rst) begin
            sync1_q  <= 5'b00000;
            sync2_q  <= 5'b00000;
            acc_q    <= 3'b000;
            pulse_q  <= 3'b000;
            cnt_q    <= '0;
            run_q    <= 1'b0;
            halted_q <= 1'b0;
            addr_q   <= {ADDR_W{1'b0}};
            presc_q  <= {PW{1'b0}};
            idx_q    <= {IW{1'b0}};
            an_q     <= {DIGITS{1'b1}};
            seg_q    <= 7'h7F;
        end else begin
            sync1_q  <= {dec, inc, mem, step, cont};
            sync2_q  <= sync1_q;
            acc_q    <= acc_d;
            pulse_q  <= pulse_d;
            cnt_q    <= cnt_d;
            run_q    <= run_d;
            halted_q <= halted_d;
            addr_q   <= addr_d;
            presc_q  <= presc_d;
            idx_q    <= idx_d;
            an_q     <= an_d;
            seg_q    <= seg_d;
        end
    end

    // Status LEDs from registered state; with ADDR_W=14 bit 13 shows the halt flag.
    always_comb begin
        led                 = 16'h0000;
        led[ADDR_W-1:0]     = addr_q;
        led[13]             = halted_q;
        led[14]             = sync2_q[S_MEM];
        led[15]             = sync2_q[S_CONT];
    end

    assign run  = run_q;
    assign addr = addr_q;
    assign an   = an_q;
    assign seg  = seg_q;

endmodule

// File: doc/ddu_ctrl.md
# ddu_ctrl

Parametrised debug/display unit (DDU) controller that sits between the board I/O and the pipeline CPU inside `Top`. It conditions the `cont`/`step`/`mem`/`inc`/`dec` controls and generates the CPU run enable. It maintains the browse address for the register file or data memory and time-multiplexes the selected 32-bit word onto a configurable number of 7-segment digits. It generalises the fixed 8-digit DDU with parametrised debounce, scan rate, address width and digit count.

## Interface
- `ADDR_W`, 8: browse address width; 1..14.
- `DIGITS`, 8: number of 7-segment digits; data width is `4*DIGITS`.
- `DEB_CYCLES`, 16: cycles a button must be stable before its level is accepted; ≥1.
- `SCAN_DIV`, 1024: clock cycles per displayed digit; ≥1.

Ports:
- `clk_500` in 1: only clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `cont` in 1: continuous-run switch; not debounced.
- `step` in 1: single-step button; debounced.
- `mem` in 1: display select: 1 = `mem_data`, 0 = `reg_data`; not debounced.
- `inc` in 1: address increment button; debounced.
- `dec` in 1: address decrement button; debounced.
- `reg_data` in 4*DIGITS: register-file read data at `addr`.
- `mem_data` in 4*DIGITS: data-memory read data at `addr`.
- `run` out 1: CPU clock enable, registered.
- `addr` out ADDR_W: browse address, registered.
- `an` out DIGITS: digit enables, active-low, one-hot when scanning.
- `seg` out 7: segments `{g,f,e,d,c,b,a}`, active-low.
- `led` out 16: status.

## Operation
- **Synchronisers.** All five control inputs pass through 2-flop synchronisers.
- **Debounce (`step`, `inc`, `dec`).**
  - Each has an accepted level (reset 0) and a counter.
  - The counter increments while the synchronised level differs from the accepted level and clears when they match.
  - On reaching `DEB_CYCLES`, the accepted level takes the new value and the counter clears.
  - A 0→1 transition of the accepted level produces a one-cycle pulse.
- **Run control.**
  - `run` <= `cont_s` | `step_pulse`.
  - When `cont_s`=1, step pulses are redundant: no extra or missing cycles.
- **Address.**
  - `inc_pulse` alone: `addr`+1, wrapping `2^ADDR_W-1`→0.
  - `dec_pulse` alone: `addr`−1, wrapping 0→`2^ADDR_W-1`.
  - Both pulses in the same cycle: `addr` holds.
- **Display scan.**
  - A prescaler counts 0..`SCAN_DIV`-1. On wrap, the digit index advances `0..DIGITS-1` and wraps to 0.
  - `an` <= ~(1<<index). `seg` <= hex encoding of nibble `index` of the selected word; digit 0 is the LSB nibble.
  - The selected word is `mem_s ? mem_data : reg_data`, sampled at the advance.
  - Hex encoding (active-low), 0..F: 40,79,24,30,19,12,02,78,00,10,08,03,46,21,06,0E.
- **LEDs.**
  - `led[15]`=`cont_s`, `led[14]`=`mem_s`, `led[13]`=halted (0 without macro).
  - `led[ADDR_W-1:0]`=`addr`; all other bits 0.
- **Reset** (any cycle, including mid-debounce or mid-scan):
  - `run`=0, `addr`=0, `an`=all 1s (blank), `seg`=7'h7F, `led`=0.
  - Counters, index, synchronisers and accepted levels clear.
  - A press in progress is discarded; no pulse follows reset.

## Timing
- Raw `step`/`inc`/`dec` held high from edge k: pulse is high in cycle k+2+`DEB_CYCLES`. `run` or `addr` updates at the following edge.
- Releases of less than `DEB_CYCLES` stable cycles are ignored, so holding a button gives exactly one pulse.
- `cont` 0→1 at edge k: `run`=1 from edge k+3. 1→0 behaves symmetrically.
- First digit appears `SCAN_DIV` cycles after reset release; a full refresh takes `DIGITS*SCAN_DIV` cycles.
- Data change: visible on a digit no later than its next scan slot.

## Configuration
- **`DDU_BREAK_EN` defined:**
  - Adds inputs `pc` (4*DIGITS) and `bp_pc` (4*DIGITS), plus an internal halted flag (reset 0).
  - While `cont_s`=1 and `pc`==`bp_pc`, the flag sets; `run` is forced 0 from the next edge.
  - The flag clears when `cont_s`=0.
  - While halted, `step_pulse` still produces a one-cycle `run`.
  - `led[13]` reflects the flag.
- **Undefined:** no `pc`/`bp_pc` ports and no halt logic; `led[13]`=0.

## Test plan
Bench parameters: `DEB_CYCLES`=4, `SCAN_DIV`=2, `DIGITS`=8, `ADDR_W`=8.
- **Reset:** `rst`=1 for 3 cycles, then 0 → `run`=0, `addr`=0, `an`=FF, `seg`=7F, `led`=0000; first `an`=FE appears 2 cycles after release.
- **Debounce:** `inc` toggled 1 for 3 cycles, 0 for 1, then held 1 for 20 cycles → exactly one increment, `addr`=01, pulse 6 cycles after the stable rise; bounce pulses = 0.
- **Address wrap and simultaneity:** from `addr`=00, `dec` press → FF; then `inc`+`dec` pressed in the same cycle → FF held; `inc` → 00.
- **Step mode:** `cont`=0, three `step` presses → `run` high for exactly 3 single cycles; `cont`=1 → `run` continuous 3 cycles after the switch.
- **Display:** `reg_data`=32'h1234ABCD, `mem`=0 → digits 0..7 show D,C,B,A,4,3,2,1 (`seg` 21,46,03,08,19,30,24,79); set `mem`=1 with `mem_data`=0 → all digits show 40.
- **Breakpoint (`DDU_BREAK_EN`):** `cont`=1, `bp_pc`=32'h0000000C, `pc` steps 0,4,8,C → `run` 0 on the edge after `pc`=C, `led[13]`=1; one `step` press gives one `run` cycle; `cont`=0 clears `led[13]`.
